// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision add/sub back end.
package fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef struct packed {
        logic g;
        logic r;
        logic s;
    } grs_t;

    function automatic fp32_t fp_inf(input logic sign);
        fp_inf = '{sign: sign, exp: 8'(EXP_MAX), frac: 23'h0};
    endfunction

endpackage

// File: rtl/lzc24.sv
// Combinational leading-zero counter over 24 bits; an all-zero input counts 24.
module lzc24 (
    input  logic [23:0] data,
    output logic [4:0]  count
);

    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned and a latch is inferred.
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (data[i]) count = 5'(23 - i);
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Normalize + round-to-nearest-even back end: two-register pipeline with valid/ready on both sides.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_carry,
    input  logic [2:0]        in_grs,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_inexact,
    output logic              out_overflow,
    output logic              out_underflow
);

    localparam int XW = EXP_W + 1;

    typedef struct packed {
        logic              sign;
        logic [XW-1:0]     exp;
        logic [MANT_W-1:0] mant;
        grs_t              grs;
    } s1_t;

    logic              en;
    logic              v1_q, v1_d, v2_q, v2_d;
    s1_t               s1_q, s1_d;
    fp32_t             res_q, res_d;
    logic              inexact_q, inexact_d, ovf_q, ovf_d, unf_q, unf_d;

    logic [4:0]        lz, sh;
    logic [MANT_W+1:0] word;
    logic              exact_zero;
    logic              up;
    logic [MANT_W:0]   m25;
    logic [XW-1:0]     e;

    assign en = !v2_q || out_ready;

    lzc24 u_lzc (
        .data  (in_mant),
        .count (lz)
    );

    assign exact_zero = !in_carry && (in_mant == '0) && (in_grs == 3'b000);

    // Stage N: normalize a carry right by one, or left by lz clamped so exp never drops below 1.
    always_comb begin
        v1_d = v1_q;
        s1_d = s1_q;
        sh   = '0;
        word = '0;
        if (en) begin
            v1_d      = in_valid;
            s1_d.sign = in_sign & ~exact_zero;
            if (in_carry) begin
                s1_d.mant = {1'b1, in_mant[MANT_W-1:1]};
                s1_d.grs  = {in_mant[0], in_grs[2], in_grs[1] | in_grs[0]};
                s1_d.exp  = XW'(in_exp) + XW'(1);
            end else begin
                if (in_exp != '0) begin
                    sh = (EXP_W'(lz) < in_exp - EXP_W'(1)) ? lz : 5'(in_exp - EXP_W'(1));
                end
                word      = {in_mant, in_grs[2], in_grs[1]} << sh;
                s1_d.mant = word[MANT_W+1:2];
                s1_d.grs  = {word[1], word[0], in_grs[0]};
                s1_d.exp  = word[MANT_W+1] ? XW'(in_exp) - XW'(sh) : '0;
            end
        end
    end

    // Stage R: round to nearest even, fold mantissa overflow and denormal promotion into the exponent.
    always_comb begin
        v2_d      = v2_q;
        res_d     = res_q;
        inexact_d = inexact_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        up        = 1'b0;
        m25       = '0;
        e         = '0;
        if (en) begin
            v2_d = v1_q;
            up   = s1_q.grs.g & (s1_q.grs.r | s1_q.grs.s | s1_q.mant[0]);
            m25  = {1'b0, s1_q.mant} + (MANT_W+1)'(up);
            e    = s1_q.exp;
            if (m25[MANT_W]) begin
                e = e + XW'(1);
            end else if ((e == '0) && m25[MANT_W-1]) begin
                e = XW'(1);
            end
            inexact_d = |s1_q.grs;
            if (e >= XW'(EXP_MAX)) begin
                res_d     = fp_inf(s1_q.sign);
                inexact_d = 1'b1;
                ovf_d     = 1'b1;
                unf_d     = 1'b0;
            end else begin
                res_d = '{sign: s1_q.sign, exp: e[EXP_W-1:0], frac: m25[MANT_W-2:0]};
                ovf_d = 1'b0;
                unf_d = (e == '0) && (|s1_q.grs);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1_q      <= '0;
            v2_q      <= 1'b0;
            res_q     <= '0;
            inexact_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
            v1_q      <= v1_d;
            s1_q      <= s1_d;
            v2_q      <= v2_d;
            res_q     <= res_d;
            inexact_q <= inexact_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign in_ready      = en;
    assign out_valid     = v2_q;
    assign out_result    = res_q;
    assign out_inexact   = inexact_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: driver pushes expected responses, a negedge monitor pops on each handshake.
module tb_fp_norm_round;
    import fp_pkg::*;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        carry;
        logic [2:0]  grs;
    } beat_t;

    typedef struct packed {
        logic [31:0] result;
        logic        inexact;
        logic        overflow;
        logic        underflow;
    } resp_t;

    logic        clk, rst;
    logic        in_valid, in_ready, in_sign, in_carry;
    logic [7:0]  in_exp;
    logic [23:0] in_mant;
    logic [2:0]  in_grs;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_inexact, out_overflow, out_underflow;

    int    checks = 0;
    int    errors = 0;
    int    stall_seen = 0;
    int    out_idx = 0;
    resp_t exp_q[$];
    resp_t held;
    bit    held_v = 0;

    fp_norm_round dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_carry      (in_carry),
        .in_grs        (in_grs),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_inexact   (out_inexact),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drives one beat from posedge+1 and pushes its expected response when accepted.
    task automatic send(input beat_t b, input resp_t r);
        int budget;
        bit done;
        in_valid = 1'b1;
        in_sign  = b.sign;
        in_exp   = b.exp;
        in_mant  = b.mant;
        in_carry = b.carry;
        in_grs   = b.grs;
        done     = 1'b0;
        budget   = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(r);
                done = 1'b1;
            end else begin
                stall_seen++;
            end
            @(posedge clk);
            #1;
            budget++;
            if (!done && budget > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", budget);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        resp_t cur, want;
        cur = {out_result, out_inexact, out_overflow, out_underflow};
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) check("hold_stable", 64'(cur), 64'(held));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected no output", cur);
                end else begin
                    want = exp_q.pop_front();
                    check($sformatf("out_%0d", out_idx), 64'(cur), 64'(want));
                    out_idx++;
                end
            end
            held_v = out_valid && !out_ready;
            held   = cur;
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_carry  = 1'b0;
        in_grs    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_word", 64'({out_result, out_inexact, out_overflow, out_underflow}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // Carry with round-up overflow: 1.FFFFFF.. x 2^1 rounds to 4.0; two-edge latency.
        send('{1'b0, 8'(EXP_BIAS), 24'hFFFFFF, 1'b1, 3'b000}, '{32'h40800000, 1'b1, 1'b0, 1'b0});
        check("lat_edge1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_edge2", 64'(out_valid), 64'd1);

        send('{1'b0, 8'(EXP_BIAS + 23), 24'h000001, 1'b0, 3'b100}, '{32'h3FC00000, 1'b0, 1'b0, 1'b0});
        send('{1'b0, 8'd127, 24'h800001, 1'b0, 3'b100}, '{32'h3F800002, 1'b1, 1'b0, 1'b0});
        send('{1'b0, 8'd127, 24'h800000, 1'b0, 3'b100}, '{32'h3F800000, 1'b1, 1'b0, 1'b0});
        send('{1'b0, 8'd127, 24'h800000, 1'b0, 3'b011}, '{32'h3F800000, 1'b1, 1'b0, 1'b0});
        send('{1'b0, 8'd1,   24'h000010, 1'b0, 3'b001}, '{32'h00000010, 1'b1, 1'b0, 1'b1});
        send('{1'b1, 8'd100, 24'h000000, 1'b0, 3'b000}, '{32'h00000000, 1'b0, 1'b0, 1'b0});
        send('{1'b1, 8'd254, 24'h800000, 1'b1, 3'b000}, '{32'hFF800000, 1'b1, 1'b1, 1'b0});
        send('{1'b0, 8'd254, 24'hFFFFFF, 1'b0, 3'b100}, '{32'h7F800000, 1'b1, 1'b1, 1'b0});
        send('{1'b0, 8'd1,   24'h7FFFFF, 1'b0, 3'b110}, '{32'h00800000, 1'b1, 1'b0, 1'b0});
        send('{1'b0, 8'd5,   24'h000100, 1'b0, 3'b000}, '{32'h00001000, 1'b0, 1'b0, 1'b0});
        send('{1'b1, 8'd130, 24'h000003, 1'b1, 3'b011}, '{32'hC1800002, 1'b1, 1'b0, 1'b0});

        // Backpressure: four back-to-back beats while the consumer stalls for three cycles.
        out_ready = 1'b0;
        stall_seen = 0;
        fork
            begin
                send('{1'b0, 8'd128, 24'hC00000, 1'b0, 3'b000}, '{32'h40400000, 1'b0, 1'b0, 1'b0});
                send('{1'b0, 8'd127, 24'h800001, 1'b0, 3'b100}, '{32'h3F800002, 1'b1, 1'b0, 1'b0});
                send('{1'b0, 8'd127, 24'h800000, 1'b0, 3'b100}, '{32'h3F800000, 1'b1, 1'b0, 1'b0});
                send('{1'b0, 8'd1,   24'h7FFFFF, 1'b0, 3'b110}, '{32'h00800000, 1'b1, 1'b0, 1'b0});
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("in_ready_dropped", 64'(stall_seen > 0), 64'd1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("stall_drain", 64'(exp_q.size()), 64'd0);

        // Reset with two beats in flight: both are discarded.
        send('{1'b0, 8'd150, 24'h000001, 1'b0, 3'b100}, '{32'h3FC00000, 1'b0, 1'b0, 1'b0});
        send('{1'b0, 8'd1,   24'h000010, 1'b0, 3'b001}, '{32'h00000010, 1'b1, 1'b0, 1'b1});
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("midrst_edge_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;

        send('{1'b1, 8'd130, 24'h000003, 1'b1, 3'b011}, '{32'hC1800002, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("final_drain", 64'(exp_q.size()), 64'd0);
        check("outputs_seen", 64'(out_idx), 64'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
